// File: rtl/alu_seq_if.sv
// rtl/alu_seq_if.sv - operand/result handshake bundle for alu_seq
interface alu_seq_if #(
  parameter int ALU_WIDTH     = 8,
  parameter int OP_CODE_WIDTH = 4
);
  logic                     in_valid;
  logic                     in_ready;
  logic [ALU_WIDTH-1:0]     in_a;
  logic [ALU_WIDTH-1:0]     in_b;
  logic [OP_CODE_WIDTH-1:0] opcode;
  logic                     out_valid;
  logic                     out_ready;
  logic [ALU_WIDTH-1:0]     alu_out;
  logic                     carry_out;
  logic                     a_is_zero;
  logic                     busy;

  modport master (
    output in_valid, in_a, in_b, opcode, out_ready,
    input  in_ready, out_valid, alu_out, carry_out, a_is_zero, busy
  );

  modport slave (
    input  in_valid, in_a, in_b, opcode, out_ready,
    output in_ready, out_valid, alu_out, carry_out, a_is_zero, busy
  );
endinterface

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - handshaked ALU with registered result and iterative shift-add multiply
module alu_seq #(
  parameter int ALU_WIDTH     = 8,
  parameter int OP_CODE_WIDTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  alu_seq_if.slave   bus
);
  localparam int SHW = $clog2(ALU_WIDTH);
  localparam int CW  = SHW + 1;
  localparam int W2  = 2 * ALU_WIDTH;

  localparam logic [3:0] OP_ADD = 4'd2;
  localparam logic [3:0] OP_AND = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_PSB = 4'd5;
  localparam logic [3:0] OP_SUB = 4'd8;
  localparam logic [3:0] OP_OR  = 4'd9;
  localparam logic [3:0] OP_SHL = 4'd10;
  localparam logic [3:0] OP_SHR = 4'd11;
  localparam logic [3:0] OP_MUL = 4'd12;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_t;

  state_t               state_q, state_d;
  logic [W2-1:0]        acc_q, acc_d;
  logic [W2-1:0]        mcand_q, mcand_d;
  logic [ALU_WIDTH-1:0] mplier_q, mplier_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 maz_q, maz_d;
  logic [ALU_WIDTH-1:0] res_q, res_d;
  logic                 carry_q, carry_d;
  logic                 az_q, az_d;
  logic                 ov_q, ov_d;

  logic [3:0]           op4;
  logic [ALU_WIDTH:0]   sum, diff;
  logic [SHW-1:0]       sh_amt;
  logic [ALU_WIDTH-1:0] sc_res;
  logic                 sc_carry;
  logic                 free;
  logic                 in_ready;

  assign op4    = bus.opcode[3:0];
  assign sh_amt = bus.in_b[SHW-1:0];

  // Single-cycle datapath; unlisted codes fall back to the legacy pass-A.
  always_comb begin
    sum      = {1'b0, bus.in_a} + {1'b0, bus.in_b};
    diff     = {1'b0, bus.in_a} - {1'b0, bus.in_b};
    sc_res   = bus.in_a;
    sc_carry = 1'b0;
    case (op4)
      OP_ADD: begin sc_res = sum[ALU_WIDTH-1:0];  sc_carry = sum[ALU_WIDTH];  end
      OP_SUB: begin sc_res = diff[ALU_WIDTH-1:0]; sc_carry = diff[ALU_WIDTH]; end
      OP_AND: sc_res = bus.in_a & bus.in_b;
      OP_XOR: sc_res = bus.in_a ^ bus.in_b;
      OP_OR:  sc_res = bus.in_a | bus.in_b;
      OP_PSB: sc_res = bus.in_b;
      OP_SHL: sc_res = bus.in_a << sh_amt;
      OP_SHR: sc_res = bus.in_a >> sh_amt;
      default: sc_res = bus.in_a;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    maz_d    = maz_q;
    res_d    = res_q;
    carry_d  = carry_q;
    az_d     = az_q;
    ov_d     = ov_q;
    in_ready = 1'b0;
    free     = !ov_q || bus.out_ready;

    if (ov_q && bus.out_ready) begin
      ov_d = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        in_ready = free;
        if (bus.in_valid && free) begin
          if (op4 == OP_MUL) begin
            mcand_d  = {{ALU_WIDTH{1'b0}}, bus.in_a};
            mplier_d = bus.in_b;
            acc_d    = '0;
            cnt_d    = '0;
            maz_d    = (bus.in_a == '0);
            state_d  = S_MUL;
          end else begin
            res_d   = sc_res;
            carry_d = sc_carry;
            az_d    = (bus.in_a == '0);
            ov_d    = 1'b1;
          end
        end
      end
      S_MUL: begin
        if (mplier_q[0]) begin
          acc_d = acc_q + mcand_q;
        end
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == CW'(ALU_WIDTH - 1)) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (free) begin
          res_d   = acc_q[ALU_WIDTH-1:0];
          carry_d = |acc_q[W2-1:ALU_WIDTH];
          az_d    = maz_q;
          ov_d    = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      maz_q    <= 1'b0;
      res_q    <= '0;
      carry_q  <= 1'b0;
      az_q     <= 1'b0;
      ov_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      maz_q    <= maz_d;
      res_q    <= res_d;
      carry_q  <= carry_d;
      az_q     <= az_d;
      ov_q     <= ov_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = ov_q;
  assign bus.alu_out   = res_q;
  assign bus.carry_out = carry_q;
  assign bus.a_is_zero = az_q;
  assign bus.busy      = (state_q != S_IDLE);
endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - randomized and directed bench for alu_seq against a transaction-level model
module tb_alu_seq;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_seq_if #(.ALU_WIDTH(W), .OP_CODE_WIDTH(4)) bus ();
  alu_seq #(.ALU_WIDTH(W), .OP_CODE_WIDTH(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int total = 0, bad = 0, cyc = 0;

  logic       iv = 1'b0, ordy = 1'b1, rsv = 1'b0;
  logic [7:0] ia = '0, ib = '0;
  logic [3:0] iop = '0;

  bit         m_ov, m_c, m_z, m_pend, m_pc, m_pz, armed;
  logic [7:0] m_res, m_pres;
  int         m_left;

  typedef struct {logic [7:0] r; logic c; logic z;} res_t;
  res_t got[$];
  bit   acc_last, prev_ov;
  int   acc_cyc, rise_cyc, rises;
  logic last_ir;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic void ref_op(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op,
                                 output logic [7:0] r, output logic c);
    int unsigned s, p;
    c = 1'b0;
    case (op)
      4'd2:  begin s = a + b; r = s[7:0]; c = (s > 255); end
      4'd3:  r = a & b;
      4'd4:  r = a ^ b;
      4'd5:  r = b;
      4'd8:  begin r = a - b; c = (a < b); end
      4'd9:  r = a | b;
      4'd10: r = a << (b % W);
      4'd11: r = a >> (b % W);
      4'd12: begin p = a * b; r = p[7:0]; c = (p > 255); end
      default: r = a;
    endcase
  endfunction

  task automatic tick();
    bit m_ir, free;
    rst_n         = rsv;
    bus.in_valid  = iv;
    bus.in_a      = ia;
    bus.in_b      = ib;
    bus.opcode    = iop;
    bus.out_ready = ordy;
    #1;
    m_ir = !m_pend && (!m_ov || ordy);
    if (armed) begin
      chk("out_valid", bus.out_valid, m_ov);
      chk("busy", bus.busy, m_pend);
      chk("in_ready", bus.in_ready, m_ir);
      if (m_ov) begin
        chk("alu_out", bus.alu_out, m_res);
        chk("carry_out", bus.carry_out, m_c);
        chk("a_is_zero", bus.a_is_zero, m_z);
      end
    end
    last_ir = bus.in_ready;
    if (bus.out_valid === 1'b1 && !prev_ov) begin
      rises++;
      rise_cyc = cyc;
    end
    prev_ov = (bus.out_valid === 1'b1);
    if (bus.out_valid === 1'b1 && ordy)
      got.push_back('{bus.alu_out, bus.carry_out, bus.a_is_zero});
    acc_last = 1'b0;
    if (!rsv) begin
      m_ov = 0; m_res = '0; m_c = 0; m_z = 0; m_pend = 0; m_left = 0;
      armed = 1;
    end else begin
      free = !m_ov || ordy;
      if (m_ov && ordy) m_ov = 0;
      if (m_pend) begin
        if (m_left > 0) m_left--;
        else if (free) begin
          m_ov = 1; m_res = m_pres; m_c = m_pc; m_z = m_pz; m_pend = 0;
        end
      end else if (iv && m_ir) begin
        acc_last = 1'b1;
        acc_cyc  = cyc;
        if (iop == 4'd12) begin
          m_pend = 1; m_left = W;
          ref_op(ia, ib, iop, m_pres, m_pc);
          m_pz = (ia == 0);
        end else begin
          ref_op(ia, ib, iop, m_res, m_c);
          m_z  = (ia == 0);
          m_ov = 1;
        end
      end
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op);
    bit ok;
    ok = 0;
    ia = a; ib = b; iop = op; iv = 1'b1;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (acc_last) begin ok = 1; break; end
    end
    if (!ok) begin
      total++; bad++;
      $display("FAIL send_timeout: op %0d never accepted", op);
    end
    iv = 1'b0;
  endtask

  task automatic idle(input int n);
    iv = 1'b0;
    repeat (n) tick();
  endtask

  initial begin
    int nr;
    @(negedge clk);
    // reset held two cycles with random inputs
    rsv = 1'b0;
    for (int i = 0; i < 2; i++) begin
      iv = 1'($urandom); ia = 8'($urandom); ib = 8'($urandom); iop = 4'($urandom); ordy = 1'($urandom);
      tick();
    end
    rsv = 1'b1; iv = 1'b0; ordy = 1'b1;
    rst_n = 1'b1; bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    #1;
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_alu_out", bus.alu_out, 0);
    chk("rst_carry", bus.carry_out, 0);
    chk("rst_a_is_zero", bus.a_is_zero, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_in_ready", bus.in_ready, 1);

    // ADD with carry, SUB with borrow
    got.delete();
    send(8'hFF, 8'h01, 4'd2);
    send(8'h03, 8'h05, 4'd8);
    idle(3);
    chk("addsub_count", got.size(), 2);
    if (got.size() == 2) begin
      chk("add_res", got[0].r, 8'h00); chk("add_carry", got[0].c, 1); chk("add_az", got[0].z, 0);
      chk("sub_res", got[1].r, 8'hFE); chk("sub_borrow", got[1].c, 1);
    end

    // single-cycle stream with out_ready low on cycles 2-3
    got.delete();
    begin
      int idx;
      logic [7:0] sa[3] = '{8'h01, 8'hF0, 8'hAA};
      logic [7:0] sb[3] = '{8'h01, 8'h3C, 8'hFF};
      logic [3:0] so[3] = '{4'd2, 4'd3, 4'd4};
      idx = 0;
      for (int c = 1; c <= 8; c++) begin
        ordy = !(c == 2 || c == 3);
        if (idx < 3) begin iv = 1'b1; ia = sa[idx]; ib = sb[idx]; iop = so[idx]; end
        else iv = 1'b0;
        tick();
        if (c == 2 || c == 3) chk("bp_in_ready_low", last_ir, 0);
        if (acc_last) idx++;
      end
      iv = 1'b0; ordy = 1'b1;
    end
    idle(2);
    chk("bp_count", got.size(), 3);
    if (got.size() == 3) begin
      chk("bp_r0", got[0].r, 8'h02); chk("bp_r1", got[1].r, 8'h30); chk("bp_r2", got[2].r, 8'h55);
    end

    // MUL latency and overflow
    got.delete();
    send(8'd13, 8'd11, 4'd12);
    idle(12);
    chk("mul_edges_to_result", rise_cyc - acc_cyc - 1, W + 1);
    send(8'd16, 8'd16, 4'd12);
    idle(12);
    chk("mul_count", got.size(), 2);
    if (got.size() == 2) begin
      chk("mul1_res", got[0].r, 8'h8F); chk("mul1_carry", got[0].c, 0);
      chk("mul2_res", got[1].r, 8'h00); chk("mul2_carry", got[1].c, 1);
    end

    // shifts and legacy pass-A
    got.delete();
    send(8'h01, 8'd9, 4'd10);
    send(8'h80, 8'd7, 4'd11);
    send(8'h00, 8'h5A, 4'd7);
    idle(3);
    chk("sh_count", got.size(), 3);
    if (got.size() == 3) begin
      chk("shl_res", got[0].r, 8'h02); chk("shr_res", got[1].r, 8'h01);
      chk("pass_res", got[2].r, 8'h00); chk("pass_az", got[2].z, 1);
    end

    // reset on the fourth multiply iteration
    got.delete();
    send(8'd7, 8'd9, 4'd12);
    idle(3);
    nr = rises;
    rsv = 1'b0; tick(); rsv = 1'b1;
    idle(15);
    chk("abort_no_rise", rises, nr);
    chk("abort_no_result", got.size(), 0);
    send(8'd2, 8'd3, 4'd2);
    idle(2);
    chk("post_abort_latency", rise_cyc - acc_cyc, 1);
    chk("post_abort_count", got.size(), 1);
    if (got.size() == 1) chk("post_abort_res", got[0].r, 8'h05);

    // randomized traffic against the model
    for (int i = 0; i < 1500; i++) begin
      rsv  = ($urandom_range(0, 199) != 0);
      iv   = 1'($urandom);
      ordy = ($urandom_range(0, 3) != 0);
      ia   = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
      ib   = 8'($urandom);
      iop  = ($urandom_range(0, 3) == 0) ? 4'd12 : 4'($urandom);
      tick();
    end
    rsv = 1'b1; ordy = 1'b1;
    idle(15);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
